// File: rtl/axi_lite_master_bridge.sv
// Turns the core's simple request/stall data-bus port into single-outstanding AXI4-Lite
// master transactions, with a response timeout so a hung slave cannot stall the core forever.
module axi_lite_master_bridge #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic                      wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] addr,
    input  logic [31:0]               wr_data,
    input  logic [3:0]                wr_strobe,
    output logic [31:0]               rd_data,
    output logic                      access_fault,
    output logic                      busy,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [2:0]                m_awprot,
    output logic [31:0]               m_wdata,
    output logic [3:0]                m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    output logic [2:0]                m_arprot,
    input  logic [31:0]               m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RESP, DRAIN} state_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                    state_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [31:0]               wData_q;
    logic [3:0]                wStrb_q;
    logic                      awValid_q, wValid_q, bReady_q, arValid_q, rReady_q;
    logic                      busy_q, fault_q;
    logic [31:0]               rdData_q;
    logic [CNT_W-1:0]          cnt_q;

    // "Left" means the channel is still owed a handshake after this cycle.
    logic awLeft, wLeft, bLeft, arLeft, rLeft, anyLeft, timeoutHit;

    assign awLeft     = awValid_q & ~m_awready;
    assign wLeft      = wValid_q  & ~m_wready;
    assign bLeft      = bReady_q  & ~m_bvalid;
    assign arLeft     = arValid_q & ~m_arready;
    assign rLeft      = rReady_q  & ~m_rvalid;
    assign anyLeft    = awLeft | wLeft | bLeft | arLeft | rLeft;
    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // On timeout the outstanding valids/readies are left untouched so RESP and DRAIN can
    // finish those handshakes legally before the next request is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            awValid_q <= 1'b0;
            wValid_q  <= 1'b0;
            bReady_q  <= 1'b0;
            arValid_q <= 1'b0;
            rReady_q  <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
            rdData_q  <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (wr_en) begin
                        addr_q    <= addr;
                        wData_q   <= wr_data;
                        wStrb_q   <= wr_strobe;
                        awValid_q <= 1'b1;
                        wValid_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= WR;
                    end else if (rd_en) begin
                        addr_q    <= addr;
                        arValid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= RA;
                    end
                end
                WR: begin
                    awValid_q <= awLeft;
                    wValid_q  <= wLeft;
                    if (!awLeft && !wLeft) begin
                        bReady_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        state_q  <= WB;
                    end else if (timeoutHit) begin
                        bReady_q <= 1'b1;
                        fault_q  <= 1'b1;
                        rdData_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                WB: begin
                    if (m_bvalid) begin
                        bReady_q <= 1'b0;
                        fault_q  <= (m_bresp != 2'b00);
                        rdData_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else if (timeoutHit) begin
                        fault_q  <= 1'b1;
                        rdData_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RA: begin
                    arValid_q <= arLeft;
                    if (!arLeft) begin
                        rReady_q <= 1'b1;
                        cnt_q    <= cnt_q + CNT_W'(1);
                        state_q  <= RD;
                    end else if (timeoutHit) begin
                        rReady_q <= 1'b1;
                        fault_q  <= 1'b1;
                        rdData_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RD: begin
                    if (m_rvalid) begin
                        rReady_q <= 1'b0;
                        fault_q  <= (m_rresp != 2'b00);
                        rdData_q <= m_rdata;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else if (timeoutHit) begin
                        fault_q  <= 1'b1;
                        rdData_q <= '0;
                        busy_q   <= 1'b0;
                        state_q  <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    awValid_q <= awLeft;
                    wValid_q  <= wLeft;
                    bReady_q  <= bLeft;
                    arValid_q <= arLeft;
                    rReady_q  <= rLeft;
                    busy_q    <= anyLeft;
                    state_q   <= anyLeft ? DRAIN : IDLE;
                end
                DRAIN: begin
                    awValid_q <= awLeft;
                    wValid_q  <= wLeft;
                    bReady_q  <= bLeft;
                    arValid_q <= arLeft;
                    rReady_q  <= rLeft;
                    if (!anyLeft) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The accept cycle stalls the core combinationally; every later stall is registered.
    assign busy         = busy_q | ((state_q == IDLE) & (rd_en | wr_en));
    assign rd_data      = rdData_q;
    assign access_fault = fault_q;
    assign m_awaddr     = addr_q;
    assign m_araddr     = addr_q;
    assign m_wdata      = wData_q;
    assign m_wstrb      = wStrb_q;
    assign m_awvalid    = awValid_q;
    assign m_wvalid     = wValid_q;
    assign m_bready     = bReady_q;
    assign m_arvalid    = arValid_q;
    assign m_rready     = rReady_q;
    assign m_awprot     = 3'b000;
    assign m_arprot     = 3'b000;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Bench for axi_lite_master_bridge: a delay-configurable AXI4-Lite slave, a table of
// transactions checked through a scoreboard, and hand sequences for timeout and reset.
module tb_axi_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wr_data;
    logic [3:0]  wr_strobe;
    logic [31:0] rd_data;
    logic        access_fault, busy;
    logic [31:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;

    always #5 clk = ~clk;

    axi_lite_master_bridge #(.AXI_ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr),
        .wr_data(wr_data), .wr_strobe(wr_strobe), .rd_data(rd_data),
        .access_fault(access_fault), .busy(busy),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          awDly, wDly, bDly, arDly, rDly;
        logic [1:0]  resp;
        logic [31:0] slaveRdata;
        logic [31:0] expRdata;
        logic        expFault;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          busyCycles;
    } exp_t;

    exp_t sb[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    int          awDly, wDly, bDly, arDly, rDly;
    bit          arEn, bEn;
    logic [1:0]  respCfg;
    logic [31:0] rdataCfg;
    int          awCnt, wCnt, arCnt, bCnt, rCnt;
    bit          awGot, wGot, arGot, pAw, pW, pAr, pB, pR;
    logic [31:0] seenAwAddr, seenWData, seenArAddr;
    logic [3:0]  seenWStrb;

    // Slave model: readies after a per-channel delay, B after both AW and W, R after AR.
    initial begin
        {awCnt, wCnt, arCnt, bCnt, rCnt} = '0;
        {awGot, wGot, arGot, pAw, pW, pAr, pB, pR} = '0;
        seenAwAddr = '0; seenWData = '0; seenArAddr = '0; seenWStrb = '0;
        forever begin
            @(negedge clk);
            if (pB && m_bvalid) begin m_bvalid = 1'b0; awGot = 0; wGot = 0; bCnt = 0; end
            if (pR && m_rvalid) begin m_rvalid = 1'b0; arGot = 0; rCnt = 0; end
            if (pAw && m_awready) awGot = 1;
            if (pW && m_wready) wGot = 1;
            if (pAr && m_arready) arGot = 1;
            if (rst) begin
                {awCnt, wCnt, arCnt, bCnt, rCnt} = '0;
                {awGot, wGot, arGot} = '0;
                m_bvalid = 1'b0;
                m_rvalid = 1'b0;
            end
            if (m_awvalid) begin
                m_awready = (awCnt >= awDly);
                if (m_awready) seenAwAddr = m_awaddr;
                awCnt++;
            end else begin m_awready = 1'b0; awCnt = 0; end
            if (m_wvalid) begin
                m_wready = (wCnt >= wDly);
                if (m_wready) begin seenWData = m_wdata; seenWStrb = m_wstrb; end
                wCnt++;
            end else begin m_wready = 1'b0; wCnt = 0; end
            if (m_arvalid) begin
                m_arready = arEn && (arCnt >= arDly);
                if (m_arready) seenArAddr = m_araddr;
                arCnt++;
            end else begin m_arready = 1'b0; arCnt = 0; end
            if (awGot && wGot && bEn && !m_bvalid) begin
                if (bCnt >= bDly) begin m_bvalid = 1'b1; m_bresp = respCfg; end
                else bCnt++;
            end
            if (arGot && !m_rvalid) begin
                if (rCnt >= rDly) begin m_rvalid = 1'b1; m_rresp = respCfg; m_rdata = rdataCfg; end
                else rCnt++;
            end
            pAw = m_awvalid; pW = m_wvalid; pAr = m_arvalid; pB = m_bready; pR = m_rready;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Waits for busy to fall (RESP cycle), then compares against the scoreboard head.
    task automatic waitResp(input string name, input int already);
        int   n = already;
        exp_t e;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput({name, " resp reached"}, busy, 1'b0);
        rd_en = 1'b0;
        wr_en = 1'b0;
        if (sb.size() == 0) begin
            checkOutput({name, " scoreboard entry"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            checkOutput({name, " rd_data"}, rd_data, e.rdata);
            checkOutput({name, " access_fault"}, access_fault, e.fault);
            if (e.busyCycles != 0) checkOutput({name, " busy cycles"}, n, e.busyCycles);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        exp_t e;
        awDly = v.awDly; wDly = v.wDly; bDly = v.bDly; arDly = v.arDly; rDly = v.rDly;
        respCfg = v.resp; rdataCfg = v.slaveRdata;
        @(negedge clk);
        wr_en = v.isWrite; rd_en = !v.isWrite;
        addr = v.addr; wr_data = v.wdata; wr_strobe = v.strb;
        e.rdata = v.expRdata;
        e.fault = v.expFault;
        e.busyCycles = v.isWrite ? 3 + ((v.awDly > v.wDly) ? v.awDly : v.wDly) + v.bDly
                                 : 3 + v.arDly + v.rDly;
        sb.push_back(e);
        #1;
        waitResp(name, 0);
        if (v.isWrite) begin
            checkOutput({name, " awaddr"}, seenAwAddr, v.addr);
            checkOutput({name, " wdata"}, seenWData, v.wdata);
            checkOutput({name, " wstrb"}, seenWStrb, v.strb);
        end else begin
            checkOutput({name, " araddr"}, seenArAddr, v.addr);
        end
    endtask

    function automatic vec_t mkVec(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s,
                                   int aw, int wd, int b, int ar, int r, logic [1:0] resp,
                                   logic [31:0] srd, logic [31:0] erd, logic ef);
        vec_t v;
        v.isWrite = w; v.addr = a; v.wdata = d; v.strb = s;
        v.awDly = aw; v.wDly = wd; v.bDly = b; v.arDly = ar; v.rDly = r;
        v.resp = resp; v.slaveRdata = srd; v.expRdata = erd; v.expFault = ef;
        return v;
    endfunction

    vec_t vecs[7];
    exp_t eh;

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; addr = '0; wr_data = '0; wr_strobe = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rresp = '0; m_rdata = '0;
        awDly = 0; wDly = 0; bDly = 0; arDly = 0; rDly = 0;
        arEn = 1; bEn = 1; respCfg = '0; rdataCfg = '0;

        vecs[0] = mkVec(0, 32'h0000_0010, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h1234_5678, 32'h1234_5678, 0);
        vecs[1] = mkVec(1, 32'h0000_0020, 32'hCAFE_F00D, 4'b0011, 2, 0, 0, 0, 0, 2'b00, 32'h5555_5555, 32'h0, 0);
        vecs[2] = mkVec(0, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 1, 2'b10, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);
        vecs[3] = mkVec(1, 32'h0000_0208, 32'h0BAD_CAFE, 4'b1111, 0, 1, 1, 0, 0, 2'b11, 32'h7777_7777, 32'h0, 1);
        vecs[4] = mkVec(0, 32'h8000_0ABC, 0, 0, 0, 0, 0, 3, 2, 2'b00, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 0);
        vecs[5] = mkVec(1, 32'h4000_0300, 32'h1357_9BDF, 4'b1000, 1, 3, 2, 0, 0, 2'b00, 32'h0, 32'h0, 0);
        vecs[6] = mkVec(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1, 0, 2'b01, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset awvalid", m_awvalid, 0);
        checkOutput("reset wvalid", m_wvalid, 0);
        checkOutput("reset arvalid", m_arvalid, 0);
        checkOutput("reset bready", m_bready, 0);
        checkOutput("reset rready", m_rready, 0);
        checkOutput("reset rd_data", rd_data, 0);
        checkOutput("reset fault", access_fault, 0);
        checkOutput("prot", {m_awprot, m_arprot}, 0);

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

        // Write with AW stalled two cycles: W completes first and drops on its own.
        awDly = 2; wDly = 0; bDly = 0; respCfg = 2'b00;
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h0000_0020; wr_data = 32'hCAFE_F00D; wr_strobe = 4'b0011;
        eh.rdata = 0; eh.fault = 0; eh.busyCycles = 5; sb.push_back(eh);
        @(negedge clk);
        checkOutput("seqW c1 awvalid", m_awvalid, 1);
        checkOutput("seqW c1 wvalid", m_wvalid, 1);
        @(negedge clk);
        checkOutput("seqW c2 wvalid", m_wvalid, 0);
        checkOutput("seqW c2 awvalid", m_awvalid, 1);
        @(negedge clk);
        checkOutput("seqW c3 bready", m_bready, 0);
        @(negedge clk);
        checkOutput("seqW c4 awvalid", m_awvalid, 0);
        checkOutput("seqW c4 bready", m_bready, 1);
        waitResp("seqW", 4);

        // Simultaneous read and write: the write wins, no AR is issued.
        awDly = 0;
        @(negedge clk);
        rd_en = 1'b1; wr_en = 1'b1; addr = 32'h0000_0030; wr_data = 32'h1111_2222; wr_strobe = 4'hF;
        eh.rdata = 0; eh.fault = 0; eh.busyCycles = 3; sb.push_back(eh);
        @(negedge clk);
        checkOutput("both c1 awvalid", m_awvalid, 1);
        checkOutput("both c1 arvalid", m_arvalid, 0);
        waitResp("both", 1);
        checkOutput("both wdata", seenWData, 32'h1111_2222);

        // Read timeout with a silent slave, then a new request waits out the drain.
        arEn = 0; arDly = 0; rDly = 0; respCfg = 2'b00; rdataCfg = 32'h0BAD_F00D;
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h0000_0040;
        eh.rdata = 0; eh.fault = 1; eh.busyCycles = 9; sb.push_back(eh);
        #1;
        waitResp("timeout", 0);
        @(negedge clk);
        rd_en = 1'b1; addr = 32'h0000_0050;
        eh.rdata = 32'h0BAD_F00D; eh.fault = 0; eh.busyCycles = 0; sb.push_back(eh);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("drain busy %0d", k), busy, 1);
            checkOutput($sformatf("drain araddr %0d", k), m_araddr, 32'h0000_0040);
        end
        arEn = 1;
        waitResp("after drain", 1);
        checkOutput("after drain araddr", seenArAddr, 32'h0000_0050);

        // Reset while waiting for B.
        bEn = 0;
        @(negedge clk);
        wr_en = 1'b1; addr = 32'h0000_0060; wr_data = 32'h6666_6666; wr_strobe = 4'hF;
        for (int k = 0; k < 20 && m_bready !== 1'b1; k++) @(negedge clk);
        checkOutput("wb reached", m_bready, 1);
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        checkOutput("rst-in-wb signals",
                    {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, busy}, 0);
        @(negedge clk);
        rst = 1'b0; bEn = 1;
        applyStimulus(vecs[0], "post-reset read");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axi_lite_master_bridge.md
Name: axi_lite_master_bridge

Overview:
Converts the core's simple AXI data-bus port (axi_rd_en, axi_wr_en, axi_addr, wr_data, wr_strobe, axi_rd_data, axi_access_fault, axi_busy) into single-outstanding AXI4-Lite master transactions toward the peripheral interconnect. It sits directly downstream of core, in place of the constant stubs that drive the AXI inputs in the core bench. It also enforces a response timeout so a hung slave cannot stall the pipeline forever.

Parameters:
AXI_ADDR_WIDTH, DEFAULT_AXI_ADDR_WIDTH, byte address width on both sides.
TIMEOUT_CYCLES, 256, cycles without a final handshake before a fault is reported; 0 disables the timeout.

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
rd_en  input  1  core read request
wr_en  input  1  core write request
addr  input  AXI_ADDR_WIDTH  core byte address
wr_data  input  32  core write data
wr_strobe  input  4  core byte enables
rd_data  output  32  read data to core
access_fault  output  1  bus error or timeout to core
busy  output  1  stall request to core
m_awaddr/m_awvalid/m_awready  out/out/in  AXI_ADDR_WIDTH/1/1  write address channel
m_awprot, m_arprot  output  3  constant 3'b000
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  write data channel
m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  write response channel
m_araddr/m_arvalid/m_arready  out/out/in  AXI_ADDR_WIDTH/1/1  read address channel
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  read data channel

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; all m_*valid, m_bready, m_rready, busy (registered part), access_fault=0; rd_data=0; timeout counter=0. Reset mid-transaction drops valids immediately (the interconnect shares the same reset).
- States: IDLE, WR (AW/W outstanding), WB (await B), RA (AR outstanding), RD (await R), RESP, DRAIN.
- IDLE: when wr_en=1, capture addr/wr_data/wr_strobe and go to WR; otherwise, when rd_en=1, capture addr and go to RA. wr_en has priority when both are high. busy=rd_en|wr_en, combinational in this cycle, so the core stalls in the accept cycle.
- WR: m_awvalid and m_wvalid assert together. Each deasserts independently on its own handshake (valid&ready). Go to WB once both have completed, including same-cycle completion.
- WB: m_bready=1. On m_bvalid, latch fault=(m_bresp!=2'b00) and go to RESP.
- RA: m_arvalid=1 until m_arready, then RD.
- RD: m_rready=1. On m_rvalid, latch rd_data=m_rdata and fault=(m_rresp!=2'b00), then go to RESP.
- busy=1 in WR, WB, RA, RD and DRAIN. The core holds its request stable while busy=1.
- RESP: lasts 1 cycle. busy=0, rd_data and access_fault are valid. rd_data=0 for writes. The next state is DRAIN if the timeout left handshakes pending, otherwise IDLE. A request present in RESP is the completing one and is not re-issued.
- Minimum latency with always-ready slave: accept at c0, first handshake at c1, final handshake at c2, RESP at c3. busy is high c0–c2 and low at c3.
- Timeout: the counter clears on accept and increments each cycle in WR/WB/RA/RD. On reaching TIMEOUT_CYCLES, go to RESP with access_fault=1 and rd_data=0, and record pending channels.
- DRAIN: keeps the pending valids and readies asserted until every handshake completes, discards the response, then returns to IDLE. busy=1 if the core requests during DRAIN; the request is accepted only from IDLE.
- access_fault and rd_data hold their values outside RESP but are meaningful only in RESP.
- Addresses pass unmodified; no alignment checks (the core handles misalignment).

Test Plan:
- Always-ready slave, read 0x0000_0010 returning 0x1234_5678/OKAY -> m_arvalid at c1, RESP at c3, rd_data=0x1234_5678, access_fault=0, busy high exactly 3 cycles.
- Write 0xCAFEF00D, strobe 4'b0011, with m_awready delayed 2 cycles and m_wready immediate -> W handshakes at c1, AW at c3, m_wvalid low from c2, m_bready at c4, RESP one cycle after bvalid.
- Read with m_rresp=2'b10 (SLVERR) -> access_fault=1 in RESP; write with m_bresp=2'b11 -> access_fault=1.
- TIMEOUT_CYCLES=8, slave never asserts m_arready -> RESP with access_fault=1 at accept+9. Next core request gets busy=1 until arready/rvalid are later supplied, then it proceeds from IDLE.
- rd_en=wr_en=1 simultaneously -> only AW/W issued, m_arvalid stays 0.
- rst=1 asserted while in WB -> next cycle IDLE, all valids/readies 0, busy=0 with no request.
